// File: rtl/debug_frame_tx.sv
// Purpose : serialises a captured pipeline snapshot into a framed UART byte stream
//           (0xA5, length, payload words MSB byte first, XOR checksum).
// Latency : first o_tx_start one cycle after the accepted i_send; each next byte one
//           cycle after the previous byte's i_tx_done.
// Backpressure: paced entirely by i_tx_done; i_send is dropped while a frame is in flight.
//
// Ports:
//   clk           single clock, rising edge
//   i_rst         synchronous active-high reset; aborts any frame in progress
//   i_send        one-cycle capture/transmit request (honoured only when idle)
//   i_snapshot    N_WORDS packed 32-bit words, word k at bits [k*32+31:k*32]
//   i_tx_done     one-cycle pulse from uart_tx when the current byte has finished
//   o_tx_start    one-cycle pulse asking uart_tx to send o_data
//   o_data        byte presented to uart_tx, stable until its i_tx_done
//   o_busy        high from the cycle after capture until the frame completes
//   o_frame_done  one-cycle pulse after the last byte's i_tx_done
module debug_frame_tx #(
  parameter int NB_DATA = 8,
  parameter int NB_32   = 32,
  parameter int N_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_send,
  input  logic [N_WORDS*NB_32-1:0] i_snapshot,
  input  logic                     i_tx_done,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_data,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int                 BUF_W    = N_WORDS * NB_32;
  localparam int                 OFF_W    = $clog2(BUF_W);
  // Byte index of the checksum: header, length, 4 bytes per word, checksum.
  localparam logic [7:0]         LAST_IDX = 8'(4 * N_WORDS + 2);
  localparam logic [NB_DATA-1:0] HDR_BYTE = NB_DATA'(8'hA5);
  localparam logic [NB_DATA-1:0] LEN_BYTE = NB_DATA'(N_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [BUF_W-1:0]     snap_q;
  logic [7:0]           idx_q;
  logic [7:0]           idx_d;
  logic [NB_DATA-1:0]   csum_q;
  logic [NB_DATA-1:0]   csum_d;
  logic                 capture;
  logic                 tx_start_d;
  logic                 frame_done_d;

  logic [7:0]           pay_idx;
  logic [5:0]           word_sel;
  logic [1:0]           lane;
  logic [OFF_W-1:0]     bit_off;
  logic [NB_DATA-1:0]   next_byte;

  // Next-state logic. Only WAIT looks at i_tx_done and only IDLE looks at
  // i_send, so stray pulses in any other state fall through harmlessly.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    capture      = 1'b0;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_send) begin
          capture    = 1'b1;
          idx_d      = 8'd0;
          csum_d     = '0;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end

      START: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (i_tx_done) begin
          // o_data still holds the byte that just finished; fold it into the
          // running checksum unless it was the header.
          if (idx_q != 8'd0) begin
            csum_d = csum_q ^ o_data;
          end
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            idx_d      = idx_q + 8'd1;
            tx_start_d = 1'b1;
            state_d    = START;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte selection for the upcoming index. Kept apart from the FSM block so the
  // checksum byte can use the already-updated csum_d without a combinational loop.
  always_comb begin
    pay_idx  = idx_d - 8'd2;
    word_sel = pay_idx[7:2];
    lane     = pay_idx[1:0];
    // lane 0 is the MSB byte of the word
    bit_off  = OFF_W'(int'(word_sel) * NB_32 + int'(2'd3 - lane) * NB_DATA);

    if (idx_d == 8'd0) begin
      next_byte = HDR_BYTE;
    end else if (idx_d == 8'd1) begin
      next_byte = LEN_BYTE;
    end else if (idx_d == LAST_IDX) begin
      next_byte = csum_d;
    end else begin
      next_byte = snap_q[bit_off +: NB_DATA];
    end
  end

  // Snapshot buffer: written only on an accepted request, so it is frozen for
  // the whole frame regardless of what i_snapshot does.
  always_ff @(posedge clk) begin
    if (!i_rst && capture) begin
      snap_q <= i_snapshot;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      csum_q       <= '0;
      o_tx_start   <= 1'b0;
      o_data       <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      o_tx_start   <= tx_start_d;
      o_busy       <= (state_d != IDLE);
      o_frame_done <= frame_done_d;
      // o_data only moves when a new byte is launched, which keeps it stable
      // from o_tx_start through the matching i_tx_done.
      if (tx_start_d) begin
        o_data <= next_byte;
      end
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Purpose : self-checking bench for debug_frame_tx (N_WORDS=8 and N_WORDS=1 instances).
// Latency : emulated uart_tx answers each o_tx_start with i_tx_done 10 cycles later.
// Backpressure: expected bytes are queued at request time and compared on each o_tx_start.
module tb_debug_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   = 1'b1;
  logic         send8 = 1'b0;
  logic         send1 = 1'b0;
  logic [255:0] snap8 = '0;
  logic [31:0]  snap1 = '0;
  logic         resp8 = 1'b0;
  logic         resp1 = 1'b0;
  logic         inj8  = 1'b0;
  logic         inj1  = 1'b0;

  logic         start8, busy8, fd8;
  logic [7:0]   data8;
  logic         start1, busy1, fd1;
  logic [7:0]   data1;

  debug_frame_tx #(.NB_DATA(8), .NB_32(32), .N_WORDS(8)) dut8 (
    .clk          (clk),
    .i_rst        (rst),
    .i_send       (send8),
    .i_snapshot   (snap8),
    .i_tx_done    (resp8 | inj8),
    .o_tx_start   (start8),
    .o_data       (data8),
    .o_busy       (busy8),
    .o_frame_done (fd8)
  );

  debug_frame_tx #(.NB_DATA(8), .NB_32(32), .N_WORDS(1)) dut1 (
    .clk          (clk),
    .i_rst        (rst),
    .i_send       (send1),
    .i_snapshot   (snap1),
    .i_tx_done    (resp1 | inj1),
    .o_tx_start   (start1),
    .o_data       (data1),
    .o_busy       (busy1),
    .o_frame_done (fd1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q8[$];
  logic [7:0] q1[$];
  int starts8 = 0, starts1 = 0, frames8 = 0, frames1 = 0;
  int cnt8 = 0, cnt1 = 0;
  logic [7:0] cur8 = 8'h00, cur1 = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame builder for the 8-word instance.
  task automatic push_model8(input logic [255:0] s);
    logic [7:0] cs;
    logic [7:0] byt;
    q8.push_back(8'hA5);
    q8.push_back(8'h08);
    cs = 8'h08;
    for (int w = 0; w < 8; w++) begin
      for (int b = 3; b >= 0; b--) begin
        byt = s[w*32 + b*8 +: 8];
        cs  = cs ^ byt;
        q8.push_back(byt);
      end
    end
    q8.push_back(cs);
  endtask

  task automatic push_deadbeef1();
    logic [7:0] exp_bytes [7];
    exp_bytes = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    for (int i = 0; i < 7; i++) q1.push_back(exp_bytes[i]);
  endtask

  task automatic go8(input logic [255:0] s);
    snap8 = s;
    send8 = 1'b1;
    push_model8(s);
    @(negedge clk);
    send8 = 1'b0;
  endtask

  // Waits for o_frame_done (bounded) and records whether o_busy ever dropped.
  task automatic wait_frame(input bit one, input string tag);
    int cyc;
    bit low;
    cyc = 0;
    low = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (!(one ? busy1 : busy8)) low = 1'b1;
    end while (!(one ? fd1 : fd8) && cyc < 2000);
    check({tag, "_frame_done"}, one ? fd1 : fd8, 1);
    check({tag, "_busy_throughout"}, low, 0);
  endtask

  // Monitor + emulated uart_tx for the 8-word instance.
  initial begin
    forever begin
      @(negedge clk);
      resp8 = 1'b0;
      if (start8 === 1'b1) begin
        starts8++;
        check("busy_at_start8", busy8, 1);
        if (q8.size() == 0) check("unexpected_start8", start8, 0);
        else                check("byte8", data8, q8.pop_front());
        cur8 = data8;
        cnt8 = 10;
      end else if (busy8 !== 1'b1) begin
        cnt8 = 0;
      end else if (cnt8 > 0) begin
        cnt8--;
        if (cnt8 == 0) begin
          resp8 = 1'b1;
          check("data_hold8", data8, cur8);
        end
      end
      if (fd8 === 1'b1) frames8++;
    end
  end

  // Monitor + emulated uart_tx for the 1-word instance.
  initial begin
    forever begin
      @(negedge clk);
      resp1 = 1'b0;
      if (start1 === 1'b1) begin
        starts1++;
        check("busy_at_start1", busy1, 1);
        if (q1.size() == 0) check("unexpected_start1", start1, 0);
        else                check("byte1", data1, q1.pop_front());
        cur1 = data1;
        cnt1 = 10;
      end else if (busy1 !== 1'b1) begin
        cnt1 = 0;
      end else if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          resp1 = 1'b1;
          check("data_hold1", data1, cur1);
        end
      end
      if (fd1 === 1'b1) frames1++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] p;
    int s0, f0, c;

    // Reset held two cycles with i_send high on both instances.
    rst   = 1'b1;
    send8 = 1'b1;
    send1 = 1'b1;
    snap8 = '1;
    snap1 = '1;
    repeat (2) @(negedge clk);
    check("rst_start8", start8, 0);
    check("rst_data8",  data8,  0);
    check("rst_busy8",  busy8,  0);
    check("rst_fd8",    fd8,    0);
    check("rst_start1", start1, 0);
    check("rst_data1",  data1,  0);
    check("rst_busy1",  busy1,  0);
    check("rst_fd1",    fd1,    0);
    rst   = 1'b0;
    send8 = 1'b0;
    send1 = 1'b0;
    repeat (20) @(negedge clk);
    check("no_start_after_rst8", starts8, 0);
    check("no_start_after_rst1", starts1, 0);

    // Single frame, word k = 0x11111111*k.
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'h11111111 * k;
    s0 = starts8; f0 = frames8;
    go8(p);
    wait_frame(1'b0, "f1");
    @(negedge clk);
    check("f1_busy_low_after", busy8, 0);
    check("f1_starts", starts8 - s0, 35);
    check("f1_frames", frames8 - f0, 1);
    check("f1_queue_empty", q8.size(), 0);

    // Mid-frame i_send and snapshot change must not disturb the frame.
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'hC0FFEE00 + k;
    s0 = starts8; f0 = frames8;
    go8(p);
    repeat (50) @(negedge clk);
    send8 = 1'b1;
    snap8 = ~p;
    @(negedge clk);
    send8 = 1'b0;
    snap8 = {8{$urandom}};
    wait_frame(1'b0, "f2");
    repeat (30) @(negedge clk);
    check("f2_starts", starts8 - s0, 35);
    check("f2_frames", frames8 - f0, 1);
    check("f2_busy_idle", busy8, 0);

    // Stray i_tx_done in IDLE, START and DONE must be ignored.
    s0 = starts8; f0 = frames8;
    inj8 = 1'b1;
    @(negedge clk);
    inj8 = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_done_ignored", starts8 - s0, 0);
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom;
    go8(p);
    check("f3_start_visible", start8, 1);
    inj8 = 1'b1;
    @(negedge clk);
    inj8 = 1'b0;
    wait_frame(1'b0, "f3");
    inj8 = 1'b1;
    @(negedge clk);
    inj8 = 1'b0;
    repeat (5) @(negedge clk);
    check("f3_starts", starts8 - s0, 35);
    check("f3_frames", frames8 - f0, 1);
    check("f3_queue_empty", q8.size(), 0);

    // Reset after byte 5, with a simultaneous i_send that must be ignored.
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'h01020304 << k;
    s0 = starts8;
    go8(p);
    c = 0;
    while (starts8 - s0 < 5 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("f4_reached_byte5", (starts8 - s0 >= 5), 1);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    send8 = 1'b1;
    q8.delete();
    @(negedge clk);
    rst   = 1'b0;
    send8 = 1'b0;
    check("midrst_start8", start8, 0);
    check("midrst_data8",  data8,  0);
    check("midrst_busy8",  busy8,  0);
    check("midrst_fd8",    fd8,    0);
    s0 = starts8; f0 = frames8;
    repeat (30) @(negedge clk);
    check("midrst_no_start", starts8 - s0, 0);
    check("midrst_no_frame", frames8 - f0, 0);
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = 32'hF00D0000 | k;
    go8(p);
    wait_frame(1'b0, "f5");
    @(negedge clk);
    check("f5_starts", starts8 - s0, 35);
    check("f5_frames", frames8 - f0, 1);

    // N_WORDS=1: two back-to-back frames of 0xDEADBEEF.
    s0 = starts1; f0 = frames1;
    snap1 = 32'hDEADBEEF;
    send1 = 1'b1;
    push_deadbeef1();
    @(negedge clk);
    send1 = 1'b0;
    wait_frame(1'b1, "n1a");
    @(negedge clk);
    check("n1_busy_low_after_done", busy1, 0);
    send1 = 1'b1;
    push_deadbeef1();
    @(negedge clk);
    send1 = 1'b0;
    check("n1_btb_accepted", busy1, 1);
    wait_frame(1'b1, "n1b");
    @(negedge clk);
    check("n1_starts", starts1 - s0, 14);
    check("n1_frames", frames1 - f0, 2);
    check("n1_queue_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
